// File: rtl/round_limit_pipe.sv
// Two-stage valid/ready convergent rounder and data limiter for the accumulator path.
// Stage 1 registers the rounding sum, stage 2 clears the fraction, limits the MSP and tracks the sticky flag.
module round_limit_pipe #(
  parameter int unsigned ACC_W  = 56,
  parameter int unsigned RND_W  = 24,
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ACC_W-1:0]  in_acc,
  input  logic              s1,
  input  logic              s0,
  input  logic              lim_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_lim,
  output logic              lim_flag,
  input  logic              clr_lim
);

  localparam int unsigned HI_LSB = RND_W + DATA_W - 1;
  localparam int unsigned HI_W   = ACC_W - HI_LSB;

  localparam logic [ACC_W-1:0] ONE      = ACC_W'(1);
  localparam logic [ACC_W-1:0] ADD_NONE = ONE << (RND_W - 1);
  localparam logic [ACC_W-1:0] ADD_DOWN = ONE << RND_W;
  localparam logic [ACC_W-1:0] ADD_UP   = ONE << (RND_W - 2);
  localparam logic [ACC_W-1:0] MASK_P0  = (ONE << RND_W) - ONE;
  localparam logic [ACC_W-1:0] MASK_P1  = (ONE << (RND_W + 1)) - ONE;

  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_UP   = 2'b10,
    MODE_RAW  = 2'b11
  } mode_e;

  mode_e             in_mode;
  logic              en;
  logic [ACC_W-1:0]  addend;
  logic [ACC_W-1:0]  sum;

  logic              st1_valid;
  logic [ACC_W-1:0]  st1_t;
  mode_e             st1_mode;
  logic              st1_lim_en;

  logic [ACC_W-1:0]  low_mask;
  logic [ACC_W-1:0]  bit_p;
  logic              conv;
  logic [ACC_W-1:0]  rnd;
  logic [HI_W-1:0]   hi_bits;
  logic              ovf;
  logic [DATA_W-1:0] data_nxt;
  logic              lim_nxt;

  assign in_mode  = mode_e'({s1, s0});
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !reset;

  // Stage 1 rounding constant; sum wraps modulo 2^ACC_W by construction.
  always_comb begin
    addend = '0;
    case (in_mode)
      MODE_NONE: addend = ADD_NONE;
      MODE_DOWN: addend = ADD_DOWN;
      MODE_UP:   addend = ADD_UP;
      default:   addend = '0;
    endcase
    sum = in_acc + addend;
  end

  // Stage 2: clear the fraction below P, then clear bit P on an exact tie.
  always_comb begin
    low_mask = '0;
    bit_p    = '0;
    conv     = 1'b0;
    case (st1_mode)
      MODE_NONE: begin
        low_mask = MASK_P0;
        bit_p    = ONE << RND_W;
        conv     = 1'b1;
      end
      MODE_DOWN: begin
        low_mask = MASK_P1;
        bit_p    = ONE << (RND_W + 1);
        conv     = 1'b1;
      end
      MODE_UP: begin
        low_mask = MASK_P0;
      end
      default: begin
        low_mask = '0;
      end
    endcase
    rnd = st1_t & ~low_mask;
    if (conv && ((st1_t & low_mask) == '0)) begin
      rnd = rnd & ~bit_p;
    end
  end

  // Limiter: overflow when the extension bits and the MSP sign disagree.
  always_comb begin
    hi_bits  = rnd[ACC_W-1:HI_LSB];
    ovf      = !((&hi_bits) || !(|hi_bits));
    data_nxt = rnd[RND_W+DATA_W-1:RND_W];
    lim_nxt  = 1'b0;
    if (st1_lim_en && ovf) begin
      data_nxt = rnd[ACC_W-1] ? SAT_NEG : SAT_POS;
      lim_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st1_valid  <= 1'b0;
      st1_t      <= '0;
      st1_mode   <= MODE_NONE;
      st1_lim_en <= 1'b0;
      out_valid  <= 1'b0;
      out_acc    <= '0;
      out_data   <= '0;
      out_lim    <= 1'b0;
      lim_flag   <= 1'b0;
    end else begin
      if (en) begin
        st1_valid <= in_valid;
        if (in_valid) begin
          st1_t      <= sum;
          st1_mode   <= in_mode;
          st1_lim_en <= lim_en;
        end
        out_valid <= st1_valid;
        if (st1_valid) begin
          out_acc  <= rnd;
          out_data <= data_nxt;
          out_lim  <= lim_nxt;
        end
      end
      // Set on a saturated beat's handshake takes priority over clear.
      if (out_valid && out_ready && out_lim) begin
        lim_flag <= 1'b1;
      end else if (clr_lim) begin
        lim_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_round_limit_pipe.sv
// Directed bench for round_limit_pipe: vector table for rounding/limiting plus
// hand sequences for stall, sticky flag priority and mid-flight reset.
module tb_round_limit_pipe;

  localparam int unsigned ACC_W  = 56;
  localparam int unsigned RND_W  = 24;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned NVEC   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ACC_W-1:0]  in_acc;
  logic              s1;
  logic              s0;
  logic              lim_en;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [DATA_W-1:0] out_data;
  logic              out_lim;
  logic              lim_flag;
  logic              clr_lim;

  always #5 clk = ~clk;

  round_limit_pipe #(.ACC_W(ACC_W), .RND_W(RND_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_acc(in_acc), .s1(s1), .s0(s0), .lim_en(lim_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_data(out_data), .out_lim(out_lim), .lim_flag(lim_flag), .clr_lim(clr_lim)
  );

  typedef struct {
    logic [ACC_W-1:0]  acc;
    logic [1:0]        mode;
    logic              lim;
    logic [ACC_W-1:0]  e_acc;
    logic [DATA_W-1:0] e_data;
    logic              e_lim;
  } vec_t;

  vec_t vecs[NVEC];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic              exp_flag;
  logic [ACC_W-1:0]  beats[4];
  logic [ACC_W-1:0]  hold;
  int                sent;
  int                got;
  int                first;

  initial begin
    vecs[0]  = '{56'h00_000000_800000, 2'b00, 1'b0, 56'h00_000000_000000, 24'h000000, 1'b0};
    vecs[1]  = '{56'h00_000001_800000, 2'b00, 1'b0, 56'h00_000002_000000, 24'h000002, 1'b0};
    vecs[2]  = '{56'h00_000001_7FFFFF, 2'b00, 1'b0, 56'h00_000001_000000, 24'h000001, 1'b0};
    vecs[3]  = '{56'h00_000001_000000, 2'b01, 1'b0, 56'h00_000000_000000, 24'h000000, 1'b0};
    vecs[4]  = '{56'h00_000003_000000, 2'b01, 1'b0, 56'h00_000004_000000, 24'h000004, 1'b0};
    vecs[5]  = '{56'h00_000000_C00000, 2'b10, 1'b0, 56'h00_000001_000000, 24'h000001, 1'b0};
    vecs[6]  = '{56'h01_000000_000000, 2'b11, 1'b1, 56'h01_000000_000000, 24'h7FFFFF, 1'b1};
    vecs[7]  = '{56'hFE_000000_000000, 2'b11, 1'b1, 56'hFE_000000_000000, 24'h800000, 1'b1};
    vecs[8]  = '{56'h01_000000_000000, 2'b11, 1'b0, 56'h01_000000_000000, 24'h000000, 1'b0};
    vecs[9]  = '{56'h7F_FFFFFF_FFFFFF, 2'b00, 1'b0, 56'h80_000000_000000, 24'h000000, 1'b0};
    vecs[10] = '{56'h7F_FFFFFF_FFFFFF, 2'b00, 1'b1, 56'h80_000000_000000, 24'h800000, 1'b1};
    vecs[11] = '{56'hFF_FFFFFF_000000, 2'b11, 1'b1, 56'hFF_FFFFFF_000000, 24'hFFFFFF, 1'b0};
    vecs[12] = '{56'hFF_FFFFFF_800000, 2'b00, 1'b0, 56'h00_000000_000000, 24'h000000, 1'b0};
    vecs[13] = '{56'hFF_FFFFFE_800000, 2'b00, 1'b1, 56'hFF_FFFFFE_000000, 24'hFFFFFE, 1'b0};
    vecs[14] = '{56'h00_000001_800000, 2'b01, 1'b0, 56'h00_000002_000000, 24'h000002, 1'b0};
    vecs[15] = '{56'h00_000000_00ABCD, 2'b11, 1'b1, 56'h00_000000_00ABCD, 24'h000000, 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_acc = '0; s1 = 1'b0; s0 = 1'b0;
    lim_en = 1'b0; out_ready = 1'b1; clr_lim = 1'b0;
    exp_flag = 1'b0;

    // Reset state
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lim", out_lim, 0);
    chk("rst_lim_flag", lim_flag, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Vector table: one beat at a time, two-cycle latency
    for (int i = 0; i < int'(NVEC); i++) begin
      in_valid = 1'b1; in_acc = vecs[i].acc; {s1, s0} = vecs[i].mode; lim_en = vecs[i].lim;
      step();
      in_valid = 1'b0; in_acc = '0; {s1, s0} = 2'b00; lim_en = 1'b0;
      chk($sformatf("v%0d_lat1_valid", i), out_valid, 0);
      step();
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_acc", i), out_acc, vecs[i].e_acc);
      chk($sformatf("v%0d_data", i), out_data, vecs[i].e_data);
      chk($sformatf("v%0d_lim", i), out_lim, vecs[i].e_lim);
      exp_flag = exp_flag | vecs[i].e_lim;
      step();
      chk($sformatf("v%0d_flag", i), lim_flag, exp_flag);
      chk($sformatf("v%0d_drained", i), out_valid, 0);
    end

    // Clear, then clear coincident with a saturating handshake
    clr_lim = 1'b1;
    step();
    clr_lim = 1'b0;
    chk("clr_alone", lim_flag, 0);
    in_valid = 1'b1; in_acc = 56'h01_000000_000000; {s1, s0} = 2'b11; lim_en = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_sat_valid", out_valid, 1);
    clr_lim = 1'b1;
    step();
    chk("clr_set_wins", lim_flag, 1);
    step();
    clr_lim = 1'b0;
    chk("clr_next_cycle", lim_flag, 0);

    // Back-to-back beats with a three-cycle consumer stall
    beats[0] = 56'h00_000011_000001;
    beats[1] = 56'h00_000022_000002;
    beats[2] = 56'h00_000033_000003;
    beats[3] = 56'h00_000044_000004;
    sent = 0; got = 0; first = -1;
    {s1, s0} = 2'b11; lim_en = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid && first < 0) first = cyc;
      out_ready = !(first >= 0 && cyc < first + 3);
      in_valid  = (sent < 4);
      in_acc    = (sent < 4) ? beats[sent] : '0;
      #1;
      if (first >= 0 && cyc < first + 3) begin
        if (cyc == first) hold = out_acc;
        else chk("stall_hold", out_acc, hold);
        chk("stall_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (got < 4) chk($sformatf("b2b_order%0d", got), out_acc, beats[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("b2b_stall_seen", (first >= 0), 1);
    chk("b2b_sent", sent, 4);
    chk("b2b_got", got, 4);

    // Reset with two beats in flight
    in_valid = 1'b1; in_acc = 56'h01_000000_000000; {s1, s0} = 2'b11; lim_en = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("pre_rst_flag", lim_flag, 1);
    in_valid = 1'b1; in_acc = 56'hFE_000000_000000;
    step();
    in_acc = 56'h00_000005_000000;
    step();
    chk("flight_valid", out_valid, 1);
    in_valid = 1'b0; reset = 1'b1;
    #1;
    chk("flight_rst_in_ready", in_ready, 0);
    step();
    chk("flight_rst_valid", out_valid, 0);
    chk("flight_rst_flag", lim_flag, 0);
    chk("flight_rst_acc", out_acc, 0);
    chk("flight_rst_data", out_data, 0);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("no_stale%0d", k), out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
